// File: rtl/spi_pkg.sv
// Shared types and constants for the SPI transfer scheduler.
package spi_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } state_t;

  localparam logic [1:0] SS_NONE = 2'b11;
  localparam logic       SLV0    = 1'b0;
  localparam logic       SLV1    = 1'b1;

endpackage

// File: rtl/spi_rr_arbiter.sv
// Combinational round-robin pick: searches req_valid starting at ptr+1 with wrap,
// returns a one-hot grant, its binary index and an any-valid flag.
module spi_rr_arbiter #(
  parameter int N_REQ = 2,
  parameter int IDX_W = 1
) (
  input  logic [N_REQ-1:0] req_valid,
  input  logic [IDX_W-1:0] ptr,
  output logic [N_REQ-1:0] grant,
  output logic [IDX_W-1:0] idx,
  output logic             any
);

  int cand;

  always_comb begin
    grant = '0;
    idx   = '0;
    any   = 1'b0;
    cand  = 0;
    for (int off = 1; off <= N_REQ; off++) begin
      cand = int'(ptr) + off;
      if (cand >= N_REQ) cand = cand - N_REQ;
      if (!any && req_valid[IDX_W'(cand)]) begin
        any                 = 1'b1;
        grant[IDX_W'(cand)] = 1'b1;
        idx                 = IDX_W'(cand);
      end
    end
  end

endmodule

// File: rtl/spi_xfer_scheduler.sv
// Round-robin scheduler sharing one dual-slave SPI master among N_REQ requesters.
// Optional WAIT timeout enabled by defining SPI_SCHED_TIMEOUT_EN.
module spi_xfer_scheduler
  import spi_pkg::*;
#(
  parameter int N_REQ       = 2,
  parameter int DATA_W      = 8,
  parameter int TIMEOUT_CYC = 255
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [N_REQ-1:0]        req_valid,
  output logic [N_REQ-1:0]        req_ready,
  input  logic [N_REQ-1:0]        req_slave,
  input  logic [N_REQ*DATA_W-1:0] req_data,
  output logic [N_REQ-1:0]        rsp_valid,
  output logic [DATA_W-1:0]       rsp_data,
  output logic                    rsp_err,
  output logic                    spi_start,
  output logic [1:0]              spi_ss_n,
  output logic [DATA_W-1:0]       spi_tx,
  input  logic                    spi_done,
  input  logic [DATA_W-1:0]       spi_rx
);

  localparam int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  // Handshake: a request transfers on any cycle where req_valid[i] and req_ready[i]
  // are both high; req_ready is a one-hot single-cycle pulse raised only in IDLE.
  state_t             state_q, state_d;
  logic [IDX_W-1:0]   ptr_q, ptr_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic               slave_q, slave_d;
  logic [DATA_W-1:0]  tx_q, tx_d;
  logic [DATA_W-1:0]  rx_q, rx_d;

  logic [N_REQ-1:0]   arb_grant;
  logic [IDX_W-1:0]   arb_idx;
  logic               arb_any;
  logic               sel_slave;
  logic [DATA_W-1:0]  sel_data;

`ifdef SPI_SCHED_TIMEOUT_EN
  localparam int              CNT_W   = $clog2(TIMEOUT_CYC + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT_CYC);
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             err_q, err_d;
`else
  logic [31:0] unused_timeout;
  assign unused_timeout = 32'(TIMEOUT_CYC);
`endif

  spi_rr_arbiter #(
    .N_REQ (N_REQ),
    .IDX_W (IDX_W)
  ) u_arb (
    .req_valid (req_valid),
    .ptr       (ptr_q),
    .grant     (arb_grant),
    .idx       (arb_idx),
    .any       (arb_any)
  );

  always_comb begin
    sel_slave = 1'b0;
    sel_data  = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (arb_idx == IDX_W'(i)) begin
        sel_slave = req_slave[i];
        sel_data  = req_data[i*DATA_W +: DATA_W];
      end
    end
  end

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    idx_d   = idx_q;
    slave_d = slave_q;
    tx_d    = tx_q;
    rx_d    = rx_q;
`ifdef SPI_SCHED_TIMEOUT_EN
    cnt_d   = cnt_q;
    err_d   = err_q;
`endif
    case (state_q)
      IDLE: begin
        if (arb_any) begin
          idx_d   = arb_idx;
          slave_d = sel_slave;
          tx_d    = sel_data;
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        state_d = WAIT;
`ifdef SPI_SCHED_TIMEOUT_EN
        cnt_d   = '0;
`endif
      end
      WAIT: begin
        // spi_done takes priority over a coincident timeout.
        if (spi_done) begin
          rx_d    = spi_rx;
          state_d = RESP;
`ifdef SPI_SCHED_TIMEOUT_EN
          err_d   = 1'b0;
`endif
        end
`ifdef SPI_SCHED_TIMEOUT_EN
        else if (cnt_q == CNT_MAX) begin
          rx_d    = '0;
          err_d   = 1'b1;
          state_d = RESP;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
`endif
      end
      RESP: begin
        ptr_d   = idx_q;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      ptr_q   <= IDX_W'(N_REQ - 1);
      idx_q   <= '0;
      slave_q <= SLV0;
      tx_q    <= '0;
      rx_q    <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      idx_q   <= idx_d;
      slave_q <= slave_d;
      tx_q    <= tx_d;
      rx_q    <= rx_d;
    end
  end

`ifdef SPI_SCHED_TIMEOUT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
      err_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      err_q <= err_d;
    end
  end
  assign rsp_err = err_q;
`else
  assign rsp_err = 1'b0;
`endif

  // Outputs decode from registered state so reset clears them without waiting for a clock.
  always_comb begin
    spi_ss_n = SS_NONE;
    if (state_q == ISSUE || state_q == WAIT) spi_ss_n[slave_q] = 1'b0;
  end

  always_comb begin
    for (int i = 0; i < N_REQ; i++) begin
      rsp_valid[i] = (state_q == RESP) && (idx_q == IDX_W'(i));
    end
  end

  assign req_ready = (state_q == IDLE) ? arb_grant : '0;
  assign spi_start = (state_q == ISSUE);
  assign spi_tx    = tx_q;
  assign rsp_data  = rx_q;

endmodule

// File: tb/tb_spi_xfer_scheduler.sv
// Self-checking bench for spi_xfer_scheduler; timeout scenario runs when SPI_SCHED_TIMEOUT_EN is defined.
module tb_spi_xfer_scheduler;

  localparam int N_REQ       = 2;
  localparam int DATA_W      = 8;
  localparam int TIMEOUT_CYC = 8;
  localparam int EW          = N_REQ + 1 + DATA_W;

  logic                    clk;
  logic                    rst_n;
  logic [N_REQ-1:0]        req_valid;
  logic [N_REQ-1:0]        req_ready;
  logic [N_REQ-1:0]        req_slave;
  logic [N_REQ*DATA_W-1:0] req_data;
  logic [N_REQ-1:0]        rsp_valid;
  logic [DATA_W-1:0]       rsp_data;
  logic                    rsp_err;
  logic                    spi_start;
  logic [1:0]              spi_ss_n;
  logic [DATA_W-1:0]       spi_tx;
  logic                    spi_done;
  logic [DATA_W-1:0]       spi_rx;

  spi_xfer_scheduler #(
    .N_REQ       (N_REQ),
    .DATA_W      (DATA_W),
    .TIMEOUT_CYC (TIMEOUT_CYC)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_slave (req_slave),
    .req_data  (req_data),
    .rsp_valid (rsp_valid),
    .rsp_data  (rsp_data),
    .rsp_err   (rsp_err),
    .spi_start (spi_start),
    .spi_ss_n  (spi_ss_n),
    .spi_tx    (spi_tx),
    .spi_done  (spi_done),
    .spi_rx    (spi_rx)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  logic [EW-1:0]    exp_q[$];
  logic [N_REQ-1:0] exp_gnt_q[$];
  int n_start = 0;
  int n_grant = 0;
  int n_rsp   = 0;
  int cyc     = 0;
  int prev_gnt_cyc = -1;
  bit gap_chk_en = 1'b0;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic mon_sample();
    logic [EW-1:0]    e;
    logic [N_REQ-1:0] g;
    cyc++;
    if (rst_n) begin
      if (spi_start) n_start++;
      if (req_ready != '0) begin
        n_grant++;
        if (exp_gnt_q.size() > 0) begin
          g = exp_gnt_q.pop_front();
          n_checks++;
          if (req_ready !== g) begin
            n_fail++;
            $display("FAIL grant_order: got %b expected %b", req_ready, g);
          end
        end
        if (gap_chk_en && prev_gnt_cyc >= 0) begin
          n_checks++;
          if (cyc - prev_gnt_cyc != 4) begin
            n_fail++;
            $display("FAIL grant_gap: got %0d cycles expected 4", cyc - prev_gnt_cyc);
          end
        end
        prev_gnt_cyc = cyc;
      end
      if (rsp_valid != '0) begin
        n_rsp++;
        n_checks++;
        if (exp_q.size() == 0) begin
          n_fail++;
          $display("FAIL spurious_rsp: got rsp_valid=%b expected none", rsp_valid);
        end else begin
          e = exp_q.pop_front();
          if ({rsp_valid, rsp_err, rsp_data} !== e) begin
            n_fail++;
            $display("FAIL rsp: got %h expected %h", {rsp_valid, rsp_err, rsp_data}, e);
          end
        end
      end
    end
  endtask

  // driver tasks
  task automatic wait_start(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (spi_start) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) begin
      n_checks++;
      n_fail++;
      $display("FAIL wait_start: got no spi_start expected one within 40 cycles");
    end
  endtask

  task automatic reply(input int lat, input logic [DATA_W-1:0] rx, input logic [N_REQ-1:0] who);
    repeat (lat) step();
    spi_done = 1'b1;
    spi_rx   = rx;
    exp_q.push_back({who, 1'b0, rx});
    step();
    spi_done = 1'b0;
    spi_rx   = DATA_W'($urandom_range(0, 255));
  endtask

  task automatic drain();
    for (int i = 0; i < 40 && exp_q.size() > 0; i++) @(negedge clk);
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: got %0d pending responses expected 0", exp_q.size());
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_checks++; if (req_ready !== 2'b00) begin n_fail++; $display("FAIL rst_req_ready: got %b expected 00", req_ready); end
    n_checks++; if (rsp_valid !== 2'b00) begin n_fail++; $display("FAIL rst_rsp_valid: got %b expected 00", rsp_valid); end
    n_checks++; if (rsp_data !== 8'h00) begin n_fail++; $display("FAIL rst_rsp_data: got %h expected 00", rsp_data); end
    n_checks++; if (rsp_err !== 1'b0) begin n_fail++; $display("FAIL rst_rsp_err: got %b expected 0", rsp_err); end
    n_checks++; if (spi_start !== 1'b0) begin n_fail++; $display("FAIL rst_spi_start: got %b expected 0", spi_start); end
    n_checks++; if (spi_ss_n !== 2'b11) begin n_fail++; $display("FAIL rst_spi_ss_n: got %b expected 11", spi_ss_n); end
    n_checks++; if (spi_tx !== 8'h00) begin n_fail++; $display("FAIL rst_spi_tx: got %h expected 00", spi_tx); end
    step();
    rst_n = 1'b1;
  endtask

  task automatic test_contention();
    int g0, s0;
    bit ok;
    logic [DATA_W-1:0] rx;
    logic [N_REQ-1:0]  who;
    g0 = n_grant;
    s0 = n_start;
    exp_gnt_q.push_back(2'b01);
    exp_gnt_q.push_back(2'b10);
    exp_gnt_q.push_back(2'b01);
    exp_gnt_q.push_back(2'b10);
    prev_gnt_cyc = -1;
    gap_chk_en = 1'b1;
    step();
    req_valid = 2'b11;
    req_slave = 2'b10;
    req_data  = {8'h21, 8'h10};
    for (int t = 0; t < 4; t++) begin
      wait_start(ok);
      if (!ok) break;
      who = (t % 2 == 0) ? 2'b01 : 2'b10;
      n_checks++;
      if ({spi_ss_n, spi_tx} !== ((t % 2 == 0) ? {2'b10, 8'h10} : {2'b01, 8'h21})) begin
        n_fail++;
        $display("FAIL contention_cmd: got ss_n=%b tx=%h in round %0d", spi_ss_n, spi_tx, t);
      end
      rx = DATA_W'($urandom_range(0, 255));
      reply(1, rx, who);
      if (t == 3) req_valid = 2'b00;
    end
    repeat (6) step();
    gap_chk_en = 1'b0;
    n_checks++; if (n_grant - g0 != 4) begin n_fail++; $display("FAIL contention_grants: got %0d expected 4", n_grant - g0); end
    n_checks++; if (n_start - s0 != 4) begin n_fail++; $display("FAIL contention_starts: got %0d expected 4", n_start - s0); end
    n_checks++; if (exp_gnt_q.size() != 0) begin n_fail++; $display("FAIL contention_order_left: got %0d expected 0", exp_gnt_q.size()); end
    drain();
  endtask

  task automatic test_single();
    bit bad;
    step();
    req_valid = 2'b01;
    req_slave = 2'b01;
    req_data  = {8'h00, 8'hA5};
    @(negedge clk);
    n_checks++; if (req_ready !== 2'b01) begin n_fail++; $display("FAIL single_ready: got %b expected 01", req_ready); end
    step();
    req_valid = 2'b00;
    @(negedge clk);
    n_checks++; if (spi_start !== 1'b1) begin n_fail++; $display("FAIL single_start: got %b expected 1", spi_start); end
    n_checks++; if (spi_ss_n !== 2'b01) begin n_fail++; $display("FAIL single_ss_issue: got %b expected 01", spi_ss_n); end
    n_checks++; if (spi_tx !== 8'hA5) begin n_fail++; $display("FAIL single_tx: got %h expected a5", spi_tx); end
    bad = 1'b0;
    repeat (9) begin
      @(negedge clk);
      if (spi_ss_n !== 2'b01 || spi_tx !== 8'hA5 || spi_start !== 1'b0 || rsp_valid !== 2'b00) bad = 1'b1;
    end
    n_checks++; if (bad) begin n_fail++; $display("FAIL single_wait_hold: got ss_n=%b tx=%h expected 01/a5 held", spi_ss_n, spi_tx); end
    reply(1, 8'h3C, 2'b01);
    @(negedge clk);
    n_checks++; if ({rsp_valid, rsp_data} !== {2'b01, 8'h3C}) begin n_fail++; $display("FAIL single_rsp: got %b/%h expected 01/3c", rsp_valid, rsp_data); end
    n_checks++; if (spi_ss_n !== 2'b11) begin n_fail++; $display("FAIL single_ss_release: got %b expected 11", spi_ss_n); end
    drain();
  endtask

  task automatic test_withdraw();
    int g0, s0;
    bit ok;
    g0 = n_grant;
    s0 = n_start;
    step();
    req_valid = 2'b01;
    req_slave = 2'b00;
    req_data  = {8'hC3, 8'h5A};
    wait_start(ok);
    step();
    req_valid = 2'b10;
    step();
    req_valid = 2'b00;
    reply(4, 8'h81, 2'b01);
    repeat (6) step();
    n_checks++; if (n_grant - g0 != 1) begin n_fail++; $display("FAIL withdraw_grants: got %0d expected 1", n_grant - g0); end
    n_checks++; if (n_start - s0 != 1) begin n_fail++; $display("FAIL withdraw_starts: got %0d expected 1", n_start - s0); end
    drain();
  endtask

  task automatic test_stray_done();
    int r0;
    r0 = n_rsp;
    step();
    spi_done = 1'b1;
    spi_rx   = 8'hEE;
    step();
    spi_done = 1'b0;
    repeat (2) step();
    n_checks++; if (n_rsp != r0) begin n_fail++; $display("FAIL stray_idle: got %0d responses expected 0", n_rsp - r0); end
    req_valid = 2'b01;
    req_slave = 2'b01;
    req_data  = {8'h00, 8'h77};
    step();
    spi_done  = 1'b1;
    req_valid = 2'b00;
    @(negedge clk);
    n_checks++; if (spi_start !== 1'b1) begin n_fail++; $display("FAIL stray_issue_start: got %b expected 1", spi_start); end
    step();
    spi_done = 1'b0;
    repeat (3) @(negedge clk);
    n_checks++; if (n_rsp != r0) begin n_fail++; $display("FAIL stray_issue: got %0d responses expected 0", n_rsp - r0); end
    reply(2, 8'h19, 2'b01);
    drain();
  endtask

  task automatic test_reset_wait();
    int r0;
    bit ok;
    r0 = n_rsp;
    step();
    req_valid = 2'b10;
    req_slave = 2'b10;
    req_data  = {8'h99, 8'h00};
    wait_start(ok);
    step();
    req_valid = 2'b00;
    step();
    rst_n = 1'b0;
    #2;
    n_checks++;
    if ({req_ready, rsp_valid, rsp_data, rsp_err, spi_start, spi_ss_n, spi_tx} !==
        {2'b00, 2'b00, 8'h00, 1'b0, 1'b0, 2'b11, 8'h00}) begin
      n_fail++;
      $display("FAIL reset_wait_outputs: got ss_n=%b start=%b tx=%h rsp=%b expected 11/0/00/00",
               spi_ss_n, spi_start, spi_tx, rsp_valid);
    end
    step();
    step();
    rst_n = 1'b1;
    repeat (4) step();
    n_checks++; if (n_rsp != r0) begin n_fail++; $display("FAIL reset_wait_no_rsp: got %0d responses expected 0", n_rsp - r0); end
    req_valid = 2'b11;
    req_slave = 2'b00;
    req_data  = {8'h66, 8'h55};
    @(negedge clk);
    n_checks++; if (req_ready !== 2'b01) begin n_fail++; $display("FAIL reset_wait_rr: got %b expected 01", req_ready); end
    wait_start(ok);
    req_valid = 2'b00;
    reply(1, 8'hB4, 2'b01);
    drain();
  endtask

`ifdef SPI_SCHED_TIMEOUT_EN
  task automatic test_timeout();
    bit ok;
    int lat;
    step();
    req_valid = 2'b10;
    req_slave = 2'b00;
    req_data  = {8'h42, 8'h00};
    wait_start(ok);
    req_valid = 2'b00;
    exp_q.push_back({2'b10, 1'b1, 8'h00});
    lat = -1;
    for (int i = 1; i <= 30; i++) begin
      @(negedge clk);
      if (rsp_valid != '0) begin
        lat = i;
        break;
      end
    end
    n_checks++; if (lat != 10) begin n_fail++; $display("FAIL timeout_latency: got %0d expected 10", lat); end
    drain();
  endtask
`endif

  initial begin
    rst_n     = 1'b0;
    req_valid = '0;
    req_slave = '0;
    req_data  = '0;
    spi_done  = 1'b0;
    spi_rx    = '0;
    fork
      forever begin
        @(negedge clk);
        mon_sample();
      end
    join_none
    test_reset();
    test_contention();
    test_single();
    test_withdraw();
    test_stray_done();
    test_reset_wait();
`ifdef SPI_SCHED_TIMEOUT_EN
    test_timeout();
`endif
    repeat (4) step();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
